sub_serial: RTL

SUB_SERIAL -- requirements
Module: sub_serial

---
 rtl/sub_serial.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sub_serial.sv
// Bit-serial subtractor: computes A-B one bit per clock, LSB first, with a
// ripple borrow held in a 1-bit register. A valid/ready handshake on each
// side; the result (difference, borrow, signed overflow) sits in a separate
// output register that only changes when a new result is completed.
module sub_serial #(
    parameter int BIT_NUM = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [BIT_NUM-1:0] A,
    input  logic [BIT_NUM-1:0] B,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [BIT_NUM-1:0] O,
    output logic               B_o,
    output logic               V_o
);

    // Six bits count up to 63, enough for the widest operand (32 bits).
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [BIT_NUM-1:0] a_sh;
    logic [BIT_NUM-1:0] b_sh;
    logic [BIT_NUM-1:0] res_sh;
    logic [BIT_NUM-1:0] o_reg;
    logic [CNT_W-1:0]   cnt;
    logic               br;
    logic               bo_reg;
    logic               vo_reg;
    logic               a_sign;
    logic               b_sign;
    logic               in_ready_reg;
    logic               out_valid_reg;

    logic               bit_a;
    logic               bit_b;
    logic               d;
    logic               br_next;
    logic               last_bit;
    logic [BIT_NUM-1:0] res_next;

    // One full-subtractor step on the current LSBs; the difference bit
    // enters the result register from the MSB end so that after BIT_NUM
    // steps the result is aligned.
    always_comb begin
        bit_a    = a_sh[0];
        bit_b    = b_sh[0];
        d        = bit_a ^ bit_b ^ br;
        br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
        res_next = res_sh >> 1;
        res_next[BIT_NUM-1] = d;
        last_bit = (cnt == CNT_W'(BIT_NUM - 1));
    end

    // Control FSM together with the datapath and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            a_sh          <= '0;
            b_sh          <= '0;
            res_sh        <= '0;
            o_reg         <= '0;
            cnt           <= '0;
            br            <= 1'b0;
            bo_reg        <= 1'b0;
            vo_reg        <= 1'b0;
            a_sign        <= 1'b0;
            b_sign        <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        a_sh         <= A;
                        b_sh         <= B;
                        // Sign bits are kept aside since the operand
                        // registers shift them away before the overflow
                        // decision is made.
                        a_sign       <= A[BIT_NUM-1];
                        b_sign       <= B[BIT_NUM-1];
                        br           <= 1'b0;
                        cnt          <= '0;
                        in_ready_reg <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    res_sh <= res_next;
                    br     <= br_next;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        o_reg         <= res_next;
                        bo_reg        <= br_next;
                        vo_reg        <= (a_sign != b_sign) &&
                                         (res_next[BIT_NUM-1] != a_sign);
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_reg;
    assign OUT_VALID = out_valid_reg;
    assign O         = o_reg;
    assign B_o       = bo_reg;
    assign V_o       = vo_reg;

endmodule
